// File: rtl/iob_eth_mii_loopback.sv
// Loopback PHY for the MII link: captures a MAC transmit frame into a buffer, checks its FCS,
// then replays the stored frame on the receive pins after an inter-frame gap.
module iob_eth_mii_loopback #(
  parameter int unsigned BUFFER_W    = 11,
  parameter int unsigned IFG_NIBBLES = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mii_tx_en_i,
  input  logic [3:0]        mii_txd_i,
  output logic              mii_rx_dv_o,
  output logic [3:0]        mii_rxd_o,
  input  logic              loop_en_i,
  output logic              frame_done_o,
  output logic [BUFFER_W:0] frame_len_o,
  output logic              crc_ok_o,
  output logic              err_o,
  output logic              dropped_o,
  output logic              busy_o
);

  localparam logic [31:0]         CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0]         CRC_RESIDUE = 32'hDEBB20E3;
  localparam int unsigned         KW          = BUFFER_W + 2;
  localparam logic [KW-1:0]       K_ONE       = KW'(1);
  localparam logic [KW-1:0]       K_SFD       = KW'(14);
  localparam logic [KW-1:0]       K_PRE_LAST  = KW'(15);
  localparam logic [15:0]         GAP_LAST    = 16'(IFG_NIBBLES - 1);
  localparam logic [BUFFER_W:0]   CNT_ONE     = (BUFFER_W + 1)'(1);
  localparam logic [BUFFER_W-1:0] ADDR_ONE    = BUFFER_W'(1);

  typedef enum logic [1:0] {C_IDLE, C_PRE, C_DATA, C_DISCARD} cap_state_t;
  typedef enum logic [1:0] {R_IDLE, R_GAP, R_PRE, R_DATA} rep_state_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  cap_state_t          c_state, c_next;
  rep_state_t          r_state, r_next;
  logic                tx_en_q;
  logic                half;
  logic [3:0]          low_nib;
  logic [BUFFER_W:0]   count;
  logic                ovf;
  logic [31:0]         crc;
  logic                start_drop;
  logic                rep_active;
  logic                count_full;
  logic                we;
  logic [7:0]          wdata;
  logic [BUFFER_W-1:0] rd_addr;
  logic [BUFFER_W-1:0] ram_addr;
  logic [7:0]          rd_data;
  logic [7:0]          hold;
  logic                load_hold;
  logic [KW-1:0]       k, k_next;
  logic [KW-1:0]       last_k;
  logic [15:0]         gap_cnt, gap_next;
  logic                dv_next;
  logic [3:0]          rxd_next;

  logic [7:0] mem [2**BUFFER_W];

  // frame_done_o counts as active so a frame cannot sneak in before replay claims the buffer
  assign rep_active = (r_state != R_IDLE) || frame_done_o;
  assign busy_o     = (r_state != R_IDLE);
  assign count_full = count[BUFFER_W];
  assign we         = (c_state == C_DATA) && mii_tx_en_i && half && !count_full;
  assign wdata      = {mii_txd_i, low_nib};
  assign ram_addr   = we ? count[BUFFER_W-1:0] : rd_addr;
  assign last_k     = {frame_len_o, 1'b0} - K_ONE;

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[ram_addr] <= wdata;
    end
    rd_data <= mem[ram_addr];
  end

  // tx_en_q resets high so a frame already running at reset release is never seen as a start
  always_comb begin
    c_next     = c_state;
    start_drop = 1'b0;
    case (c_state)
      C_IDLE: begin
        if (mii_tx_en_i) begin
          if (mii_txd_i == 4'h5 && !tx_en_q && !rep_active) begin
            c_next = C_PRE;
          end else begin
            c_next     = C_DISCARD;
            start_drop = 1'b1;
          end
        end
      end
      C_PRE: begin
        if (!mii_tx_en_i)            c_next = C_IDLE;
        else if (mii_txd_i == 4'hD)  c_next = C_DATA;
        else if (mii_txd_i != 4'h5)  c_next = C_DISCARD;
      end
      C_DATA:    if (!mii_tx_en_i) c_next = C_IDLE;
      C_DISCARD: if (!mii_tx_en_i) c_next = C_IDLE;
      default:   c_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c_state      <= C_IDLE;
      tx_en_q      <= 1'b1;
      half         <= 1'b0;
      low_nib      <= '0;
      count        <= '0;
      ovf          <= 1'b0;
      crc          <= '1;
      frame_done_o <= 1'b0;
      frame_len_o  <= '0;
      crc_ok_o     <= 1'b0;
      err_o        <= 1'b0;
      dropped_o    <= 1'b0;
    end else begin
      c_state      <= c_next;
      tx_en_q      <= mii_tx_en_i;
      frame_done_o <= 1'b0;
      dropped_o    <= start_drop;
      if (c_state == C_PRE && c_next == C_DATA) begin
        count <= '0;
        crc   <= '1;
        half  <= 1'b0;
        ovf   <= 1'b0;
      end
      if (c_state == C_DATA) begin
        if (mii_tx_en_i) begin
          if (!half) begin
            low_nib <= mii_txd_i;
            half    <= 1'b1;
          end else begin
            half <= 1'b0;
            if (count_full) begin
              ovf <= 1'b1;
            end else begin
              count <= count + CNT_ONE;
              crc   <= crc32_byte(crc, {mii_txd_i, low_nib});
            end
          end
        end else begin
          frame_done_o <= 1'b1;
          frame_len_o  <= count;
          err_o        <= half | ovf;
          crc_ok_o     <= (crc == CRC_RESIDUE) && !(half | ovf);
        end
      end
    end
  end

  // Next-state logic also computes the nibble for the following cycle so rx pins are registered.
  // rd_addr runs one byte ahead; the byte lands in hold as its low nibble goes out.
  always_comb begin
    r_next    = r_state;
    k_next    = k;
    gap_next  = gap_cnt;
    dv_next   = 1'b0;
    rxd_next  = 4'h0;
    load_hold = 1'b0;
    rd_addr   = '0;
    case (r_state)
      R_IDLE: begin
        if (frame_done_o && loop_en_i && frame_len_o != '0) begin
          r_next   = R_GAP;
          gap_next = '0;
        end
      end
      R_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          r_next   = R_PRE;
          k_next   = '0;
          dv_next  = 1'b1;
          rxd_next = 4'h5;
        end else begin
          gap_next = gap_cnt + 16'd1;
        end
      end
      R_PRE: begin
        dv_next = 1'b1;
        if (k == K_PRE_LAST) begin
          r_next    = R_DATA;
          k_next    = '0;
          rxd_next  = rd_data[3:0];
          load_hold = 1'b1;
        end else begin
          k_next   = k + K_ONE;
          rxd_next = (k == K_SFD) ? 4'hD : 4'h5;
        end
      end
      R_DATA: begin
        rd_addr = k[BUFFER_W:1] + ADDR_ONE;
        if (k == last_k) begin
          r_next = R_IDLE;
        end else begin
          dv_next = 1'b1;
          k_next  = k + K_ONE;
          if (k[0]) begin
            rxd_next  = rd_data[3:0];
            load_hold = 1'b1;
          end else begin
            rxd_next = hold[7:4];
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= R_IDLE;
      k           <= '0;
      gap_cnt     <= '0;
      hold        <= '0;
      mii_rx_dv_o <= 1'b0;
      mii_rxd_o   <= '0;
    end else begin
      r_state     <= r_next;
      k           <= k_next;
      gap_cnt     <= gap_next;
      mii_rx_dv_o <= dv_next;
      mii_rxd_o   <= rxd_next;
      if (load_hold) begin
        hold <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_iob_eth_mii_loopback.sv
// Directed bench for iob_eth_mii_loopback: default instance plus a BUFFER_W=6 instance for overflow,
// replay nibbles checked against a scoreboard of transmitted frames.
module tb_iob_eth_mii_loopback;

  localparam int IFG = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_en;
  logic [3:0]  txd;
  logic        loop_en;

  logic        rx_dv, frame_done, crc_ok, err, dropped, busy;
  logic [3:0]  rxd;
  logic [11:0] len;
  logic        s_rx_dv, s_frame_done, s_crc_ok, s_err, s_dropped, s_busy;
  logic [3:0]  s_rxd;
  logic [6:0]  s_len;

  iob_eth_mii_loopback #(.BUFFER_W(11), .IFG_NIBBLES(IFG)) dut (
    .clk_i(clk), .rst_i(rst), .mii_tx_en_i(tx_en), .mii_txd_i(txd),
    .mii_rx_dv_o(rx_dv), .mii_rxd_o(rxd), .loop_en_i(loop_en),
    .frame_done_o(frame_done), .frame_len_o(len), .crc_ok_o(crc_ok),
    .err_o(err), .dropped_o(dropped), .busy_o(busy)
  );

  iob_eth_mii_loopback #(.BUFFER_W(6), .IFG_NIBBLES(IFG)) dut_s (
    .clk_i(clk), .rst_i(rst), .mii_tx_en_i(tx_en), .mii_txd_i(txd),
    .mii_rx_dv_o(s_rx_dv), .mii_rxd_o(s_rxd), .loop_en_i(loop_en),
    .frame_done_o(s_frame_done), .frame_len_o(s_len), .crc_ok_o(s_crc_ok),
    .err_o(s_err), .dropped_o(s_dropped), .busy_o(s_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] frm[$];
  logic [4:0] exp_q[$];
  int         run_q[$];

  int  since_busy = 1000;
  int  run_len    = 0;
  bit  in_run     = 1'b0;
  bit  busy_q     = 1'b0;
  int  n_drop     = 0;
  int  n_done     = 0;
  logic [4:0] e_nib;
  int  e_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // n total bytes, the last four being the FCS sent LSB first
  task automatic build_frame(input int n, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    c = '1;
    for (int i = 0; i < n - 4; i++) begin
      b = 8'((i * 37 + seed * 11 + (i >> 3)) & 255);
      frm.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  task automatic push_expected();
    for (int i = 0; i < 15; i++) exp_q.push_back(5'h5);
    exp_q.push_back(5'hD);
    foreach (frm[i]) begin
      exp_q.push_back({1'b0, frm[i][3:0]});
      exp_q.push_back({1'b0, frm[i][7:4]});
    end
    run_q.push_back(16 + 2 * frm.size());
  endtask

  task automatic drive(input logic [3:0] n);
    @(posedge clk);
    #1;
    tx_en = 1'b1;
    txd   = n;
  endtask

  task automatic send(input bit extra);
    for (int i = 0; i < 15; i++) drive(4'h5);
    drive(4'hD);
    foreach (frm[i]) begin
      drive(frm[i][3:0]);
      drive(frm[i][7:4]);
    end
    if (extra) drive(4'hA);
    @(posedge clk);
    #1;
    tx_en = 1'b0;
    txd   = 4'h0;
  endtask

  task automatic wait_done(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = frame_done;
    end
    check({tag, "_done"}, 32'(got), 32'd1);
  endtask

  task automatic wait_dv(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = rx_dv;
    end
    check({tag, "_dv"}, 32'(got), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3000 && !idle; i++) begin
      @(negedge clk);
      idle = !busy && !s_busy;
    end
    check({tag, "_idle"}, 32'(idle), 32'd1);
  endtask

  // Replay monitor: nibble stream, run length, gap length, idle-zero rxd
  always @(negedge clk) begin
    if (rst) begin
      in_run  = 1'b0;
      run_len = 0;
      busy_q  = 1'b0;
    end else begin
      if (busy && !busy_q) since_busy = 0;
      else                 since_busy++;
      busy_q = busy;
      n_drop += int'(dropped);
      n_done += int'(frame_done);
      if (rx_dv) begin
        if (!in_run) begin
          check("gap_len", 32'(since_busy), 32'(IFG));
          in_run  = 1'b1;
          run_len = 0;
        end
        run_len++;
        e_nib = (exp_q.size() != 0) ? exp_q.pop_front() : 5'h10;
        check("rxd", 32'(rxd), 32'(e_nib));
      end else begin
        check("rxd_idle", 32'(rxd), 32'd0);
        if (in_run) begin
          in_run = 1'b0;
          e_run  = (run_q.size() != 0) ? run_q.pop_front() : -1;
          check("dv_len", 32'(run_len), 32'(e_run));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, f0;
    rst = 1'b1; tx_en = 1'b0; txd = 4'h0; loop_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dv",   32'(rx_dv), 32'd0);
    check("rst_rxd",  32'(rxd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_len",  32'(len), 32'd0);
    check("rst_crc",  32'(crc_ok), 32'd0);
    check("rst_err",  32'(err), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_s_len", 32'(s_len), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // good 64-byte frame, exactly fills the small buffer
    loop_en = 1'b1;
    build_frame(64, 1);
    push_expected();
    send(1'b0);
    wait_done("good");
    check("good_len",   32'(len), 32'd64);
    check("good_crc",   32'(crc_ok), 32'd1);
    check("good_err",   32'(err), 32'd0);
    check("good_s_len", 32'(s_len), 32'd64);
    check("good_s_crc", 32'(s_crc_ok), 32'd1);
    check("good_s_err", 32'(s_err), 32'd0);
    @(negedge clk);
    check("good_pulse", 32'(frame_done), 32'd0);
    check("good_busy",  32'(busy), 32'd1);
    wait_idle("good");
    check("good_q", 32'(exp_q.size()), 32'd0);
    repeat (8) @(posedge clk);

    // bad FCS: still replayed with the flipped byte
    build_frame(64, 1);
    frm[10] = frm[10] ^ 8'hFF;
    push_expected();
    send(1'b0);
    wait_done("bad");
    check("bad_len", 32'(len), 32'd64);
    check("bad_crc", 32'(crc_ok), 32'd0);
    check("bad_err", 32'(err), 32'd0);
    wait_idle("bad");
    check("bad_q", 32'(exp_q.size()), 32'd0);
    repeat (8) @(posedge clk);

    // overflow on the small buffer, no replay
    loop_en = 1'b0;
    build_frame(70, 2);
    send(1'b0);
    wait_done("ovf");
    check("ovf_s_len", 32'(s_len), 32'd64);
    check("ovf_s_err", 32'(s_err), 32'd1);
    check("ovf_s_crc", 32'(s_crc_ok), 32'd0);
    check("ovf_len",   32'(len), 32'd70);
    check("ovf_crc",   32'(crc_ok), 32'd1);
    repeat (5) @(negedge clk);
    check("ovf_noloop", 32'(busy), 32'd0);
    repeat (8) @(posedge clk);

    // odd nibble count: 129 data nibbles
    build_frame(64, 3);
    send(1'b1);
    wait_done("odd");
    check("odd_len",   32'(len), 32'd64);
    check("odd_err",   32'(err), 32'd1);
    check("odd_crc",   32'(crc_ok), 32'd0);
    check("odd_s_err", 32'(s_err), 32'd1);
    repeat (8) @(posedge clk);

    // collision: second frame 5 cycles into the preamble; loop_en drop must not abort
    loop_en = 1'b1;
    build_frame(64, 4);
    push_expected();
    send(1'b0);
    wait_done("col");
    wait_dv("col");
    repeat (4) @(posedge clk);
    d0 = n_drop;
    f0 = n_done;
    loop_en = 1'b0;
    build_frame(20, 5);
    send(1'b0);
    wait_idle("col");
    check("col_drop", 32'(n_drop - d0), 32'd1);
    check("col_done", 32'(n_done - f0), 32'd0);
    check("col_q",    32'(exp_q.size()), 32'd0);
    repeat (8) @(posedge clk);

    // reset during replay data
    loop_en = 1'b1;
    build_frame(64, 6);
    push_expected();
    send(1'b0);
    wait_done("rstm");
    wait_dv("rstm");
    repeat (26) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstm_dv",   32'(rx_dv), 32'd0);
    check("rstm_busy", 32'(busy), 32'd0);
    check("rstm_len",  32'(len), 32'd0);
    exp_q.delete();
    run_q.delete();
    repeat (8) @(posedge clk);

    // recovery with a short frame
    build_frame(20, 7);
    push_expected();
    send(1'b0);
    wait_done("rec");
    check("rec_len", 32'(len), 32'd20);
    check("rec_crc", 32'(crc_ok), 32'd1);
    wait_idle("rec");
    check("rec_q", 32'(exp_q.size()), 32'd0);
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iob_eth_mii_loopback.md
IOB_ETH_MII_LOOPBACK -- requirements
Module: iob_eth_mii_loopback

Purpose: PHY-side far end of the MAC MII link. Captures frames the MAC transmits (MTxEn/MTxD), checks FCS, replays each frame onto the MAC receive pins (MRxDv/MRxD). Used as a loopback PHY in simulation and FPGA self-test.

Interface
REQ-001 SHALL have parameter BUFFER_W, default 11, log2 of frame buffer capacity in bytes.
REQ-002 SHALL have parameter IFG_NIBBLES, default 24, idle cycles between capture end and replay start.
REQ-003 SHALL have one clock and a synchronous, active-high reset, as listed in REQ-004 and REQ-005.
REQ-004 SHALL have port clk_i, input, 1 bit: the MII clock, shared by the capture and replay sides.
REQ-005 SHALL have port rst_i, input, 1 bit: synchronous reset, active high.
REQ-006 SHALL have port mii_tx_en_i, input, 1 bit: MAC transmit enable.
REQ-007 SHALL have port mii_txd_i, input, 4 bits: MAC transmit nibble.
REQ-008 SHALL have port mii_rx_dv_o, output, 1 bit: receive data valid driven to the MAC.
REQ-009 SHALL have port mii_rxd_o, output, 4 bits: receive nibble driven to the MAC.
REQ-010 SHALL have port loop_en_i, input, 1 bit: enables replay of captured frames.
REQ-011 SHALL have port frame_done_o, output, 1 bit: single-cycle pulse when a capture ends.
REQ-012 SHALL have port frame_len_o, output, BUFFER_W+1 bits: bytes stored for the last frame, after SFD and including FCS.
REQ-013 SHALL have port crc_ok_o, output, 1 bit: status of the last frame.
REQ-014 SHALL have port err_o, output, 1 bit: last frame had an odd nibble count or overflowed.
REQ-015 SHALL have port dropped_o, output, 1 bit: single-cycle pulse when a frame is ignored.
REQ-016 SHALL have port busy_o, output, 1 bit: replay in progress, including the gap.

Function
REQ-017 Capture FSM states SHALL be C_IDLE, C_PRE, C_DATA and C_DISCARD.
REQ-018 C_IDLE SHALL go to C_PRE when tx_en=1 and txd=0x5 while replay is idle.
REQ-019 C_IDLE SHALL go to C_DISCARD on tx_en=1 in any other case.
REQ-020 C_PRE transitions:
- txd=0x5: stay in C_PRE.
- txd=0xD: go to C_DATA; clear the byte count; set the CRC to 0xFFFFFFFF.
- any other nibble: go to C_DISCARD.
- tx_en=0: go to C_IDLE with no frame_done.
REQ-021 C_DATA byte assembly: the first nibble is the low nibble and the second the high nibble; byte = {second, first}.
REQ-022 C_DATA SHALL write each byte to the buffer at address = byte count, then increment the count.
REQ-023 The CRC SHALL be reflected CRC-32 (poly 0xEDB88320), updated byte-wise over all bytes including the FCS.
REQ-024 C_DATA SHALL end on tx_en=0, going to C_IDLE and pulsing frame_done_o in the following cycle.
REQ-025 On capture end, frame_len_o, crc_ok_o and err_o SHALL update in the same cycle as the frame_done_o pulse.
REQ-026 crc_ok_o SHALL be 1 iff the final CRC register equals 0xDEBB20E3 and err_o=0.
REQ-027 A half byte pending at tx_en fall SHALL be discarded and SHALL set err_o.
REQ-028 Overflow: once the count reaches 2^BUFFER_W, further bytes SHALL be dropped, the count SHALL hold, and err_o SHALL be set.
REQ-029 C_DISCARD SHALL return to C_IDLE on tx_en=0, with no buffer writes and no frame_done.
REQ-030 A frame starting (tx_en rising) while busy_o=1 SHALL be handled in C_DISCARD, with dropped_o pulsing once at its start.
REQ-031 Replay FSM states SHALL be R_IDLE, R_GAP, R_PRE and R_DATA.
REQ-032 On frame_done with loop_en_i=1 and frame_len>0, replay SHALL go R_IDLE->R_GAP; busy_o SHALL rise the cycle after frame_done.
REQ-033 Replay SHALL ignore the err_o/crc_ok_o status: even bad frames are replayed as stored.
REQ-034 R_GAP SHALL last IFG_NIBBLES cycles with rx_dv=0.
REQ-035 R_PRE SHALL drive 15 nibbles of 0x5 followed by one nibble of 0xD, with rx_dv=1.
REQ-036 R_DATA SHALL drive each stored byte low nibble first, then high nibble, for 2*frame_len cycles with rx_dv=1.
REQ-037 The buffer read SHALL have 1-cycle latency and be prefetched during R_PRE so that R_DATA has no bubbles.
REQ-038 mii_rx_dv_o and mii_rxd_o SHALL be registered.
REQ-039 rx_dv SHALL stay high for exactly 16+2*frame_len consecutive cycles; mii_rxd_o SHALL be 0 whenever rx_dv=0.
REQ-040 After the last nibble, replay SHALL return to R_IDLE and busy_o SHALL fall.
REQ-041 loop_en_i SHALL be sampled only at frame_done; deasserting it mid-replay SHALL NOT abort the replay.
REQ-042 The buffer SHALL be a single-port RAM of 2^BUFFER_W x 8, owned by capture or by replay, never both at once.

Reset
REQ-043 In the cycle after rst_i=1, both FSMs SHALL be idle and all outputs SHALL be 0 (frame_len_o=0, crc_ok_o=0, err_o=0, busy_o=0, rx_dv=0, rxd=0).
REQ-044 Reset SHALL take effect mid-capture or mid-replay and abort the operation; buffer contents are don't-care.
REQ-045 While rst_i=1, mii_tx_en_i SHALL be ignored; a frame already active when reset is released SHALL be handled in C_DISCARD.

Verification
REQ-046 Good frame: 64-byte frame with valid FCS, loop_en=1 -> frame_done, len=64, crc_ok=1, err=0; rx_dv rises 24 cycles after busy_o rises and lasts 144 cycles; the nibble stream matches the transmitted bytes.
REQ-047 Bad FCS: same 64-byte frame with byte 10 flipped -> crc_ok=0, err=0; the frame is still replayed with the flipped byte.
REQ-048 Overflow: BUFFER_W=6, 70-byte frame -> len=64, err=1, crc_ok=0.
REQ-049 Odd nibbles: 129 data nibbles -> len=64, err=1, crc_ok=0.
REQ-050 Collision: a second frame starts 5 cycles into R_PRE -> dropped_o pulses once, the replay completes unchanged, and there is no second frame_done.
REQ-051 Reset mid-replay: rst_i asserted 1 cycle during R_DATA -> the next cycle has rx_dv=0 and busy_o=0, and len=0.
